codificador_de_requisicao: RTL

Front-end encoder for the user/feature request path: conditions the raw board inputs (user-level switches, feature high-bit switch, active-low push buttons) for both users. Turns them into debounced, registered 3-bit User/Func codes with a valid/ack handshake. Sits between the board pins and the priority-comparison/feature-decoding logic, which is the consumer (Ack source).

---
 rtl/codificador_de_requisicao_pkg.sv | 17 +
 rtl/codificador_de_requisicao_filtro.sv | 54 +++++
 rtl/codificador_de_requisicao.sv | 139 +++++++++++++
 3 files changed

// File: rtl/codificador_de_requisicao_pkg.sv
// Shared definitions for the request encoder.
//   - estado_t     : handshake FSM states (IDLE / VALID)
//   - SWITCH_REST  : idle level of the raw switches
//   - BUTTON_REST  : idle level of the raw active-low buttons (released)
//   - USER_PILOTO  : user code that, on both users at once, requests autopilot
package codificador_de_requisicao_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } estado_t;

  localparam logic       SWITCH_REST = 1'b0;
  localparam logic       BUTTON_REST = 1'b1;
  localparam logic [2:0] USER_PILOTO = 3'b111;

endpackage

// File: rtl/codificador_de_requisicao_filtro.sv
// filtro_de_entrada: conditions one raw board input.
// A SYNC_STAGES-deep synchronizer feeds a debounce filter. The stable output
// only follows the synchronized input after it has differed from the current
// stable value for DEBOUNCE_CYCLES consecutive edges; any return to the stable
// value restarts the count.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (everything returns to REST_LEVEL)
//   raw    : asynchronous board input
//   stable : debounced, synchronized level
module filtro_de_entrada #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   SYNC_STAGES     = 2,
  parameter logic REST_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int             CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   stable_reg;
  logic [CNT_W-1:0]       count_reg;
  logic                   synced;

  assign synced = sync_reg[SYNC_STAGES-1];
  assign stable = stable_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg   <= {SYNC_STAGES{REST_LEVEL}};
      stable_reg <= REST_LEVEL;
      count_reg  <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
      if (synced != stable_reg) begin
        if (count_reg == CNT_LAST) begin
          stable_reg <= synced;
          count_reg  <= '0;
        end else begin
          count_reg <= count_reg + 1'b1;
        end
      end else begin
        count_reg <= '0;
      end
    end
  end

endmodule

// File: rtl/codificador_de_requisicao.sv
// codificador_de_requisicao: front-end encoder for the user/feature request
// path. Filters the twelve raw board inputs of both users and publishes
// registered 3-bit User/Func codes with a Valid/Ack handshake.
// Ports:
//   Clock, Reset_n             : clock, asynchronous active-low reset
//   CH_User0/1                 : raw user-level switches
//   CH_Func0/1                 : raw feature bit 2 switches
//   BTN0_n..BTN3_n             : raw active-low buttons (feature bits 1/0)
//   Ack                        : consumer accepted the published codes
//   User0/1, Func0/1           : published codes (buttons reported pressed = 1)
//   Valid                      : published codes are new and unacknowledged
//   Piloto                     : autopilot request (both users at USER_PILOTO)
// Optional feature macro: PILOTO_DETECT_EN (undefined: Piloto tied to 0).
module codificador_de_requisicao
  import codificador_de_requisicao_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [2:0] CH_User0,
  input  logic       CH_Func0,
  input  logic       BTN0_n,
  input  logic       BTN1_n,
  input  logic [2:0] CH_User1,
  input  logic       CH_Func1,
  input  logic       BTN2_n,
  input  logic       BTN3_n,
  input  logic       Ack,
  output logic [2:0] User0,
  output logic [2:0] User1,
  output logic [2:0] Func0,
  output logic [2:0] Func1,
  output logic       Valid,
  output logic       Piloto
);

  // Word layout: [11:9] user0, [8:6] func0, [5:3] user1, [2:0] func1.
  localparam logic [11:0] REST_WORD = {
    {3{SWITCH_REST}}, SWITCH_REST, BUTTON_REST, BUTTON_REST,
    {3{SWITCH_REST}}, SWITCH_REST, BUTTON_REST, BUTTON_REST
  };

  logic [11:0] raw_word;
  logic [11:0] stable_word;
  logic [11:0] candidate;

  assign raw_word = {CH_User0, CH_Func0, BTN0_n, BTN1_n,
                     CH_User1, CH_Func1, BTN2_n, BTN3_n};

  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_filtro
      filtro_de_entrada #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES),
        .REST_LEVEL      (REST_WORD[gi])
      ) u_filtro (
        .clk    (Clock),
        .rst_n  (Reset_n),
        .raw    (raw_word[gi]),
        .stable (stable_word[gi])
      );
    end
  endgenerate

  // Departure from rest reads as 1: switches pass through, buttons invert.
  assign candidate = stable_word ^ REST_WORD;

  estado_t     state_reg, state_next;
  logic [11:0] pub_reg, pub_next;
  logic        valid_reg, valid_next;
`ifdef PILOTO_DETECT_EN
  logic        piloto_reg, piloto_next;
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg  <= IDLE;
      pub_reg    <= '0;
      valid_reg  <= 1'b0;
`ifdef PILOTO_DETECT_EN
      piloto_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      pub_reg    <= pub_next;
      valid_reg  <= valid_next;
`ifdef PILOTO_DETECT_EN
      piloto_reg <= piloto_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    pub_next    = pub_reg;
    valid_next  = valid_reg;
`ifdef PILOTO_DETECT_EN
    piloto_next = piloto_reg;
`endif
    case (state_reg)
      IDLE: begin
        // Publish in the same edge the difference is seen.
        if (candidate != pub_reg) begin
          pub_next    = candidate;
          valid_next  = 1'b1;
          state_next  = VALID;
`ifdef PILOTO_DETECT_EN
          piloto_next = (candidate[11:9] == USER_PILOTO) &&
                        (candidate[5:3]  == USER_PILOTO);
`endif
        end
      end
      VALID: begin
        // Codes frozen until the consumer acknowledges; a pending input
        // change is picked up from IDLE one edge later.
        if (Ack) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign User0 = pub_reg[11:9];
  assign Func0 = pub_reg[8:6];
  assign User1 = pub_reg[5:3];
  assign Func1 = pub_reg[2:0];
  assign Valid = valid_reg;
`ifdef PILOTO_DETECT_EN
  assign Piloto = piloto_reg;
`else
  assign Piloto = 1'b0;
`endif

endmodule
